// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the dm_sized data memory.
// Holds the access-size codes, the FSM state type and the alignment helper.
package dm_pkg;

    localparam logic [1:0] DM_SZ_BYTE = 2'b00;
    localparam logic [1:0] DM_SZ_HALF = 2'b01;
    localparam logic [1:0] DM_SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dm_state_t;

    // Low address bits that must be zero for an access of the given size.
    // The reserved size code behaves as a word.
    function automatic logic [1:0] dm_align_mask(input logic [1:0] size);
        case (size)
            DM_SZ_BYTE: return 2'b00;
            DM_SZ_HALF: return 2'b01;
            default:    return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// dm_lane_ext: byte-lane selection for the data memory.
// Picks the addressed byte/half out of a raw 32-bit word and extends it for
// loads, and produces the matching byte-lane enables used by stores.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o,
    output logic [3:0]  be_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_i[{off_i, 3'b000} +: 8];
    assign half_sel = raw_i[{off_i[1], 4'b0000} +: 16];

    // Lane select, extension and byte enables by access size.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ext_o = raw_i;
        be_o  = 4'b1111;
        case (size_i)
            DM_SZ_BYTE: begin
                ext_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
                be_o  = 4'b0001 << off_i;
            end
            DM_SZ_HALF: begin
                ext_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
                be_o  = 4'b0011 << {off_i[1], 1'b0};
            end
            default: begin
                ext_o = raw_i;
                be_o  = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dm_sized.sv
// dm_sized: parametrised byte-addressed data memory with a req/done handshake
// and WAIT_CYCLES wait states per access.
// Optional feature macro DM_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete with err=1 and have no effect; otherwise they are silently aligned.
module dm_sized
    import dm_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_BYTES),
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err
);

    dm_state_t         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept;

    logic              we_q;
    logic              sext_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_lat;

    logic              done_q;
    logic [31:0]       rdata_q;
    logic              misaligned;

    logic [ADDR_W-3:0] word_hi;
    logic [31:0]       raw_word;
    logic [31:0]       load_ext;
    logic [31:0]       wdata_lane;
    logic [3:0]        byte_en;
    logic              commit_store;
    logic              commit_load;

    logic [7:0]        mem [DEPTH_BYTES];

`ifdef DM_MISALIGN_TRAP_EN
    logic err_q;

    assign addr_lat   = addr;
    assign misaligned = |(addr_q[1:0] & dm_align_mask(size_q));

    // Error flag: cleared on acceptance, set at completion of a misaligned access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state_q == RESP) begin
            err_q <= misaligned;
        end
    end

    assign err = err_q;
`else
    assign addr_lat   = {addr[ADDR_W-1:2], addr[1:0] & ~dm_align_mask(size)};
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    // Next state and wait-counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= DM_SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= we;
            sext_q  <= sign_ext;
            size_q  <= size;
            addr_q  <= addr_lat;
            wdata_q <= wdata;
        end
    end

    assign word_hi      = addr_q[ADDR_W-1:2];
    assign raw_word     = {mem[{word_hi, 2'd3}], mem[{word_hi, 2'd2}],
                           mem[{word_hi, 2'd1}], mem[{word_hi, 2'd0}]};
    assign wdata_lane   = wdata_q << {addr_q[1:0], 3'b000};
    assign commit_store = (state_q == RESP) &&  we_q && !misaligned;
    assign commit_load  = (state_q == RESP) && !we_q && !misaligned;

    dm_lane_ext u_lane_ext (
        .size_i     (size_q),
        .sign_ext_i (sext_q),
        .off_i      (addr_q[1:0]),
        .raw_i      (raw_word),
        .ext_o      (load_ext),
        .be_o       (byte_en)
    );

    // Completion pulse and load result, both launched from the RESP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            done_q <= (state_q == RESP);
            if (commit_load) begin
                rdata_q <= load_ext;
            end
        end
    end

    // Byte-lane store commit.
    // NOTE: the array has no reset; contents survive rst_n and a reset port would block RAM mapping.
    always_ff @(posedge clk) begin
        if (commit_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[{word_hi, 2'(i)}] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_sized.sv
// tb_dm_sized: scoreboard bench for dm_sized. Two instances run side by side,
// one with no wait states and one with three; a byte-array model predicts
// every completion and a monitor compares it when done pulses.
module tb_dm_sized;

    localparam int DEPTH = 1024;
    localparam int W0    = 0;
    localparam int W1    = 3;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        req_a   [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        err_a   [2];
    logic [31:0] rdata_a [2];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        exp_q [$];
    logic [7:0]  mem_m [2][DEPTH];
    logic [31:0] lr    [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dm_sized #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_a[0]), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy_a[0]),
        .done(done_a[0]), .rdata(rdata_a[0]), .err(err_a[0])
    );

    dm_sized #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_a[1]), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy_a[1]),
        .done(done_a[1]), .rdata(rdata_a[1]), .err(err_a[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: applies one access to the byte array and returns what
    // the DUT must report at done.
    function automatic exp_t model(input int d, input bit w, input logic [1:0] sz,
                                   input bit sx, input logic [9:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n;
        int          base;
        logic [31:0] v;
        n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.dut   = d;
        e.err   = 1'b0;
        e.acc   = 0;
        e.rdata = lr[d];
`ifdef DM_MISALIGN_TRAP_EN
        if ((int'(a) % n) != 0) begin
            e.err = 1'b1;
            return e;
        end
        base = int'(a);
`else
        base = int'(a) - (int'(a) % n);
`endif
        if (w) begin
            for (int i = 0; i < n; i++) mem_m[d][(base + i) % DEPTH] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[d][(base + i) % DEPTH]) << (8 * i));
            if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            lr[d]   = v;
            e.rdata = v;
        end
        return e;
    endfunction

    // Issue one access on DUT d from a negedge with the DUT idle; returns at the
    // negedge of the done cycle. hold keeps req asserted (with a different
    // address) for that many extra cycles while the DUT is busy.
    task automatic access(input int d, input bit w, input logic [1:0] sz, input bit sx,
                          input logic [9:0] a, input logic [31:0] wd, input int hold);
        exp_t e;
        int   bc;
        bit   got;
        e       = model(d, w, sz, sx, a, wd);
        e.acc   = cyc + 1;
        exp_q.push_back(e);
        we       = w;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = wd;
        req_a[d] = 1'b1;
        bc  = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            req_a[d] = (k < hold);
            if (k < hold) addr = addr ^ 10'h100;
            if (done_a[d]) got = 1'b1;
            else if (busy_a[d]) bc++;
        end
        req_a[d] = 1'b0;
        if (!got) check("done_timeout", 32'(got), 32'd1);
        check("busy_cycles", 32'(bc), 32'(wait_of(d) + 1));
    endtask

    // Monitor: every done pulse pops the oldest expectation and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n && done_a[d]) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_done", 32'(done_a[d]), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_dut", 32'(d), 32'(e.dut));
                        check("rdata", rdata_a[d], e.rdata);
                        check("err", 32'(err_a[d]), 32'(e.err));
                        check("latency", 32'(cyc - e.acc), 32'(1 + wait_of(d)));
                        check("busy_in_done", 32'(busy_a[d]), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] misal_exp;
        rst_n    = 1'b0;
        req_a[0] = 1'b0;
        req_a[1] = 1'b0;
        we       = 1'b0;
        size     = 2'd0;
        sign_ext = 1'b0;
        addr     = '0;
        wdata    = '0;
        lr[0]    = 32'd0;
        lr[1]    = 32'd0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 8'h00;

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_busy", 32'(busy_a[d]), 32'd0);
            check("reset_done", 32'(done_a[d]), 32'd0);
            check("reset_rdata", rdata_a[d], 32'd0);
            check("reset_err", 32'(err_a[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Clear both arrays so the model and the DUTs start from the same contents.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i += 4) access(d, 1'b1, 2'd2, 1'b0, 10'(i), 32'd0, 0);

        // Word / byte / half sequence with no wait states.
        access(0, 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0);
        access(0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0);
        check("word_load_10", rdata_a[0], 32'hDEADBEEF);
        access(0, 1'b1, 2'd0, 1'b0, 10'h011, 32'h00000080, 0);
        check("store_keeps_rdata", rdata_a[0], 32'hDEADBEEF);
        access(0, 1'b0, 2'd0, 1'b1, 10'h011, 32'h0, 0);
        check("sbyte_load_11", rdata_a[0], 32'hFFFFFF80);
        access(0, 1'b0, 2'd0, 1'b0, 10'h011, 32'h0, 0);
        check("ubyte_load_11", rdata_a[0], 32'h00000080);
        access(0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0);
        check("word_after_byte", rdata_a[0], 32'hDEAD80EF);
        access(0, 1'b1, 2'd1, 1'b0, 10'h020, 32'h00001234, 0);
        access(0, 1'b0, 2'd1, 1'b1, 10'h020, 32'h0, 0);
        check("shalf_1234", rdata_a[0], 32'h00001234);
        access(0, 1'b1, 2'd1, 1'b0, 10'h020, 32'h00008001, 0);
        access(0, 1'b0, 2'd1, 1'b1, 10'h020, 32'h0, 0);
        check("shalf_8001", rdata_a[0], 32'hFFFF8001);

        // Misaligned word store.
        access(0, 1'b1, 2'd2, 1'b0, 10'h042, 32'hAABBCCDD, 0);
`ifdef DM_MISALIGN_TRAP_EN
        check("misal_err", 32'(err_a[0]), 32'd1);
        misal_exp = 32'h00000000;
`else
        check("misal_err", 32'(err_a[0]), 32'd0);
        misal_exp = 32'hAABBCCDD;
`endif
        access(0, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0, 0);
        check("misal_word_40", rdata_a[0], misal_exp);

        // Three wait states; req kept high while busy must be ignored.
        access(1, 1'b1, 2'd2, 1'b0, 10'h010, 32'h5A5AC3C3, 0);
        access(1, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 2);
        check("w3_word_load", rdata_a[1], 32'h5A5AC3C3);
        access(1, 1'b0, 2'd0, 1'b1, 10'h011, 32'h0, 2);
        check("w3_sbyte_load", rdata_a[1], 32'hFFFFFFC3);

        // Randomised traffic on both instances.
        for (int n = 0; n < 300; n++) begin
            access(n % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 10'($urandom_range(0, DEPTH - 1)),
                   $urandom, 0);
        end

        // Reset during the wait phase of a store aborts it.
        we       = 1'b1;
        size     = 2'd2;
        sign_ext = 1'b0;
        addr     = 10'h030;
        wdata    = 32'h11223344;
        req_a[1] = 1'b1;
        @(negedge clk);
        req_a[1] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("abort_busy", 32'(busy_a[d]), 32'd0);
            check("abort_done", 32'(done_a[d]), 32'd0);
            check("abort_rdata", rdata_a[d], 32'd0);
            check("abort_err", 32'(err_a[d]), 32'd0);
        end
        lr[0] = 32'd0;
        lr[1] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1, 1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 0);
        check("abort_no_write", rdata_a[1], 32'h00000000);

        repeat (10) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
